multicycle_ctrl: RTL and testbench

- Moore-style main control FSM for the multicycle MIPS CPU.
- Sequences one shared ALU, one shared instruction/data memory and the register file over 3-5 cycles per instruction.
- Emits the 3-bit ALUOp consumed by the ALU controller (001 add, 010 slti, 100 beq/sub, 000 R-type decode by funct), plus all datapath mux/enable controls.
- Stalls on a memory-ready handshake.

---
 rtl/multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences the shared ALU,
// the unified instruction/data memory and the register file, stalling on mem_ready_i.
module multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_source_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_REGA = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MDR  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   op_legal;

    always_comb begin
        case (opcode_i)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ,
            OP_ADDI, OP_SLTI, OP_LW, OP_SW: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    // Async reset forces IDLE, and IDLE decodes to all-zero outputs, so an
    // in-flight write is dropped the moment reset asserts.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (mem_ready_i) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
                    OP_RTYPE:         state_nxt = (funct_i == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_SLTI: state_nxt = S_EXEC_I;
                    OP_BEQ:           state_nxt = S_BRANCH;
                    OP_J:             state_nxt = S_JUMP;
                    OP_JAL:           state_nxt = S_JAL;
                    default:          state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_nxt = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) state_nxt = S_FETCH;
            S_EXEC_R:   state_nxt = S_R_WB;
            S_EXEC_I:   state_nxt = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: state_nxt = S_FETCH;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write  = mem_ready_i;
                ctrl.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ctrl.alu_src_b  = SRCB_IMM2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.instr_done = !TRAP_ON_ILLEGAL && !op_legal;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = WB_MDR;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready_i;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RD;
                ctrl.mem_to_reg = WB_ALU;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RT;
                ctrl.mem_to_reg = WB_ALU;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_OUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JMP;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_JMP;
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = DST_RA;
                ctrl.mem_to_reg = WB_LINK;
                ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCS_REGA;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign pc_source_o     = ctrl.pc_source;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign reg_write_o     = ctrl.reg_write;
    assign reg_dst_o       = ctrl.reg_dst;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign instr_done_o    = ctrl.instr_done;
    assign illegal_o       = ctrl.illegal;
    assign state_o         = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction cycle traces are built from
// the instruction class and stall plan, queued, and compared by a negedge monitor.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic       done;
        logic       ill;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic [5:0] opcode_i = '0;
    logic [5:0] funct_i = '0;

    ov_t  obs [2];
    ov_t  q0[$];
    ov_t  q1[$];
    ov_t  tr[$];
    logic rq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0 traps on illegal opcodes, instance 1 treats them as NOPs.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw, asa, done, ill;
        logic [1:0] pcs, rdst, m2r, asb;
        logic [2:0] aop;
        logic [3:0] st;
        multicycle_ctrl #(.TRAP_ON_ILLEGAL(g == 0)) dut (
            .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
            .mem_ready_i(mem_ready_i), .pc_write_o(pcw), .pc_write_cond_o(pcwc),
            .pc_source_o(pcs), .i_or_d_o(iord), .mem_read_o(mrd), .mem_write_o(mwr),
            .ir_write_o(irw), .reg_write_o(rw), .reg_dst_o(rdst), .mem_to_reg_o(m2r),
            .alu_src_a_o(asa), .alu_src_b_o(asb), .alu_op_o(aop),
            .instr_done_o(done), .illegal_o(ill), .state_o(st)
        );
        assign obs[g] = {st, pcw, pcwc, pcs, iord, mrd, mwr, irw, rw, rdst, m2r, asa, asb, aop, done, ill};
    end

    task automatic chk(input string nm, input ov_t a, input ov_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got state=%0d vec=%h, want state=%0d vec=%h", nm, a.st, a, e.st, e);
        end
    endtask

    // Monitor: one expected vector per cycle per instance, plus the read/write exclusion rule.
    initial forever begin
        @(negedge clk);
        if (q0.size() > 0) chk("trace_dut0", obs[0], q0.pop_front());
        if (q1.size() > 0) chk("trace_dut1", obs[1], q1.pop_front());
        for (int g = 0; g < 2; g++) begin
            n_chk++;
            if (obs[g].mrd && obs[g].mwr) begin
                n_fail++;
                $display("FAIL rd_wr_excl dut%0d: got mem_read=1 mem_write=1, want not both", g);
            end
        end
    end

    function automatic ov_t z(input logic [3:0] s);
        ov_t v;
        v = '0;
        v.st = s;
        return v;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};
    endfunction

    task automatic add(input ov_t v, input logic r);
        tr.push_back(v);
        rq.push_back(r);
    endtask

    // Reference: cycle-by-cycle expectation of one instruction, from its class,
    // fs FETCH stall cycles and ms memory-phase stall cycles.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fs,
                         input int ms, input bit trap);
        ov_t v;
        tr.delete();
        rq.delete();
        for (int i = 0; i <= fs; i++) begin
            v = z(1); v.mrd = 1; v.asb = 2'b01; v.aop = 3'b001;
            v.irw = (i == fs); v.pcw = (i == fs);
            add(v, i == fs);
        end
        v = z(2); v.asb = 2'b11; v.aop = 3'b001; v.done = !legal(op) && !trap;
        add(v, 1'($urandom_range(0, 1)));
        if (op == 35 || op == 43) begin
            v = z(3); v.asa = 1; v.asb = 2'b10; v.aop = 3'b001;
            add(v, 1'($urandom_range(0, 1)));
        end
        if (op == 35) begin
            for (int i = 0; i <= ms; i++) begin
                v = z(4); v.mrd = 1; v.iord = 1;
                add(v, i == ms);
            end
            v = z(5); v.rw = 1; v.m2r = 2'b01; v.done = 1;
            add(v, 1'($urandom_range(0, 1)));
        end else if (op == 43) begin
            for (int i = 0; i <= ms; i++) begin
                v = z(6); v.mwr = 1; v.iord = 1; v.done = (i == ms);
                add(v, i == ms);
            end
        end else if (op == 0 && fn != 8) begin
            v = z(7); v.asa = 1; add(v, 1'($urandom_range(0, 1)));
            v = z(8); v.rw = 1; v.rdst = 2'b01; v.done = 1; add(v, 1'($urandom_range(0, 1)));
        end else if (op == 8 || op == 10) begin
            v = z(9); v.asa = 1; v.asb = 2'b10; v.aop = (op == 10) ? 3'b010 : 3'b001;
            add(v, 1'($urandom_range(0, 1)));
            v = z(10); v.rw = 1; v.done = 1; add(v, 1'($urandom_range(0, 1)));
        end else if (op == 4) begin
            v = z(11); v.asa = 1; v.aop = 3'b100; v.pcwc = 1; v.pcs = 2'b01; v.done = 1;
            add(v, 1'($urandom_range(0, 1)));
        end else if (op == 2) begin
            v = z(12); v.pcw = 1; v.pcs = 2'b10; v.done = 1; add(v, 1'($urandom_range(0, 1)));
        end else if (op == 3) begin
            v = z(13); v.pcw = 1; v.pcs = 2'b10; v.rw = 1; v.rdst = 2'b10; v.m2r = 2'b10; v.done = 1;
            add(v, 1'($urandom_range(0, 1)));
        end else if (op == 0) begin
            v = z(14); v.pcw = 1; v.pcs = 2'b11; v.done = 1; add(v, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
        opcode_i = op;
        funct_i  = fn;
        build(op, fn, fs, ms, 1'b1);
        for (int i = 0; i < tr.size(); i++) begin
            mem_ready_i = rq[i];
            q0.push_back(tr[i]);
            q1.push_back(tr[i]);
            @(posedge clk); #1;
        end
    endtask

    // Asserting reset must clear outputs before any clock edge; IDLE then lasts one cycle.
    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        chk("async_reset_dut0", obs[0], z(0));
        chk("async_reset_dut1", obs[1], z(0));
        @(posedge clk); #1;
        rst_i = 1'b1;
        mem_ready_i = 1'($urandom_range(0, 1));
        q0.push_back(z(0));
        q1.push_back(z(0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op, fn;
        ov_t a, b, c, t;
        ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd10, 6'd4, 6'd2, 6'd3};

        do_reset();
        issue(6'd0, 6'h20, 0, 0);
        issue(6'd35, 6'h15, 2, 3);
        issue(6'd10, 6'h08, 0, 0);
        issue(6'd4, 6'h00, 0, 0);
        issue(6'd3, 6'h01, 1, 0);
        issue(6'd0, 6'd8, 0, 0);
        issue(6'd43, 6'h3F, 0, 2);
        issue(6'd8, 6'h00, 0, 0);
        issue(6'd2, 6'h08, 0, 0);

        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 7)];
            fn = 6'($urandom_range(0, 63));
            if (op == 0) begin
                if ($urandom_range(0, 3) == 0) fn = 6'd8;
                else if (fn == 6'd8) fn = 6'd9;
            end
            issue(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled store.
        opcode_i = 6'd43;
        funct_i  = 6'd0;
        build(6'd43, 6'd0, 0, 5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 3) ? 1'b0 : rq[i];
            q0.push_back(tr[i]);
            q1.push_back(tr[i]);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk); #1;
        do_reset();
        issue(6'd0, 6'h22, 0, 0);

        // Illegal opcode: instance 0 traps and holds, instance 1 loops FETCH/DECODE.
        do_reset();
        opcode_i = 6'h3F;
        funct_i  = 6'd0;
        build(6'h3F, 6'd0, 0, 0, 1'b1);
        a = tr[0];
        b = tr[1];
        build(6'h3F, 6'd0, 0, 0, 1'b0);
        c = tr[1];
        t = z(15);
        t.ill = 1'b1;
        for (int k = 0; k < 11; k++) begin
            mem_ready_i = 1'b1;
            q0.push_back((k == 0) ? a : t);
            q1.push_back(a);
            @(posedge clk); #1;
            mem_ready_i = 1'($urandom_range(0, 1));
            q0.push_back((k == 0) ? b : t);
            q1.push_back(c);
            @(posedge clk); #1;
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
